// File: rtl/hex_pkg.sv
// hex_pkg: shared types and character constants for the hex word assembler.
package hex_pkg;
    typedef enum logic [1:0] {ST_ACCEPT, ST_DECODE, ST_OUTPUT, ST_FLUSH} hex_asm_state_t;
    typedef enum logic [1:0] {ERR_NONE = 2'd0, ERR_BADCHAR = 2'd1, ERR_OVERFLOW = 2'd2} err_cause_t;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    function automatic logic is_term(input logic [7:0] c);
        return (c == CHAR_CR) || (c == CHAR_LF);
    endfunction
endpackage

// File: rtl/hex_word_assembler_decoder.sv
// hexDecoderUnit: registered ASCII hex digit decoder, no reset; case-insensitive A-F.
module hexDecoderUnit (
    input  logic       clk,
    input  logic [7:0] nibbleChar,
    output logic [3:0] nibble,
    output logic       badChar
);
    logic       is_digit, is_alpha;
    logic [3:0] nib_d;
    always_comb begin
        is_digit = (nibbleChar >= 8'h30) && (nibbleChar <= 8'h39);
        is_alpha = ((nibbleChar >= 8'h41) && (nibbleChar <= 8'h46)) ||
                   ((nibbleChar >= 8'h61) && (nibbleChar <= 8'h66));
        // low nibble of 'A'/'a' is 1, so adding 9 yields 10..15
        nib_d    = is_digit ? nibbleChar[3:0] : nibbleChar[3:0] + 4'd9;
    end
    always_ff @(posedge clk) begin
        nibble  <= nib_d;
        badChar <= !(is_digit || is_alpha);
    end
endmodule

// File: rtl/hex_word_assembler.sv
// hex_word_assembler: shifts ASCII hex digits into a right-aligned word, emitted on CR/LF;
// bad or overlong lines raise an error pulse and are discarded up to the next terminator.
module hex_word_assembler
    import hex_pkg::*;
#(
    parameter int DIGITS = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [7:0]                   char_in,
    input  logic                         char_valid,
    output logic                         char_ready,
    output logic [4*DIGITS-1:0]          word_out,
    output logic [$clog2(DIGITS+1)-1:0]  word_digits,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic                         error,
    output logic [1:0]                   err_cause
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    hex_asm_state_t state_q, state_d;
    logic [W-1:0]   acc_q, acc_d, word_q, word_d;
    logic [CW-1:0]  cnt_q, cnt_d, digits_q, digits_d;
    logic           error_q, error_d;
    err_cause_t     cause_q, cause_d;
    logic [3:0]     nibble;
    logic           bad_char, accept, term;

    hexDecoderUnit u_dec (
        .clk        (clk),
        .nibbleChar (char_in),
        .nibble     (nibble),
        .badChar    (bad_char)
    );

    assign char_ready  = (state_q == ST_ACCEPT) || (state_q == ST_FLUSH);
    assign word_valid  = (state_q == ST_OUTPUT);
    assign word_out    = word_q;
    assign word_digits = digits_q;
    assign error       = error_q;
    assign err_cause   = cause_q;
    assign accept      = char_valid && char_ready;
    assign term        = is_term(char_in);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        digits_d = digits_q;
        error_d  = 1'b0;
        cause_d  = cause_q;
        case (state_q)
            ST_ACCEPT: if (accept) begin
                if (term) begin
                    if (cnt_q != '0) begin
                        state_d  = ST_OUTPUT;
                        word_d   = acc_q;
                        digits_d = cnt_q;
                    end
                end else if (cnt_q == CW'(DIGITS)) begin
                    state_d = ST_FLUSH;
                    error_d = 1'b1;
                    cause_d = ERR_OVERFLOW;
                end else begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: if (bad_char) begin
                state_d = ST_FLUSH;
                error_d = 1'b1;
                cause_d = ERR_BADCHAR;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                state_d = ST_ACCEPT;
                acc_d   = {acc_q[W-5:0], nibble};
                cnt_d   = cnt_q + CW'(1);
            end
            ST_OUTPUT: if (word_ready) begin
                state_d = ST_ACCEPT;
                acc_d   = '0;
                cnt_d   = '0;
            end
            default: if (accept && term) begin
                state_d = ST_ACCEPT;
                acc_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_ACCEPT;
            acc_q    <= '0;
            cnt_q    <= '0;
            word_q   <= '0;
            digits_q <= '0;
            error_q  <= 1'b0;
            cause_q  <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            digits_q <= digits_d;
            error_q  <= error_d;
            cause_q  <= cause_d;
        end
    end
endmodule

// File: tb/tb_hex_word_assembler.sv
// tb_hex_word_assembler: directed character streams with hand-computed words and error pulses.
module tb_hex_word_assembler;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  char_in = 8'h00;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic [31:0] word_out;
    logic [3:0]  word_digits;
    logic        word_valid;
    logic        word_ready = 1'b1;
    logic        error;
    logic [1:0]  err_cause;

    int          vectors = 0;
    int          miscompares = 0;
    int          words = 0;
    int          errs = 0;
    int          vcyc = 0;
    logic [31:0] last_word = '0;
    logic [3:0]  last_digits = '0;

    hex_word_assembler #(.DIGITS(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .char_in     (char_in),
        .char_valid  (char_valid),
        .char_ready  (char_ready),
        .word_out    (word_out),
        .word_digits (word_digits),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .error       (error),
        .err_cause   (err_cause)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (word_valid) vcyc <= vcyc + 1;
        if (word_valid && word_ready) begin
            words       <= words + 1;
            last_word   <= word_out;
            last_digits <= word_digits;
        end
        if (error) errs <= errs + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] c);
        int n = 0;
        @(negedge clk);
        char_in    = c;
        char_valid = 1'b1;
        while (!char_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("char_ready_timeout", 32'(char_ready), 32'd1);
        @(posedge clk);
        #1 char_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_char_ready"}, 32'(char_ready), 32'd1);
        check({tag, "_word_out"}, word_out, 32'd0);
        check({tag, "_word_digits"}, 32'(word_digits), 32'd0);
        check({tag, "_word_valid"}, 32'(word_valid), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_err_cause"}, 32'(err_cause), 32'd0);
    endtask

    initial begin
        #12 check_reset_outputs("reset");
        @(negedge clk) rst_n = 1'b1;

        send_str("1A3F\r");
        check("term_valid_next", 32'(word_valid), 32'd1);
        idle(3);
        check("w1_count", 32'(words), 32'd1);
        check("w1_word", last_word, 32'h00001A3F);
        check("w1_digits", 32'(last_digits), 32'd4);
        check("w1_valid_cycles", 32'(vcyc), 32'd1);

        send_str("deadBEEF\n");
        idle(3);
        check("w2_word", last_word, 32'hDEADBEEF);
        check("w2_digits", 32'(last_digits), 32'd8);

        send_str("12G");
        check("bad_not_yet", 32'(error), 32'd0);
        idle(1);
        check("bad_error", 32'(error), 32'd1);
        check("bad_cause", 32'(err_cause), 32'd1);
        idle(1);
        check("bad_pulse_end", 32'(error), 32'd0);
        send_str("4\n");
        idle(3);
        check("bad_no_word", 32'(words), 32'd2);
        check("bad_err_count", 32'(errs), 32'd1);
        send_str("7\r");
        idle(3);
        check("after_bad_word", last_word, 32'h00000007);
        check("after_bad_digits", 32'(last_digits), 32'd1);

        send_str("123456789");
        check("ovf_error", 32'(error), 32'd1);
        check("ovf_cause", 32'(err_cause), 32'd2);
        send_str("\r");
        idle(3);
        check("ovf_no_word", 32'(words), 32'd3);
        check("ovf_err_count", 32'(errs), 32'd2);
        send_str("\n5\n");
        idle(3);
        check("after_ovf_word", last_word, 32'h00000005);
        check("after_ovf_count", 32'(words), 32'd4);

        word_ready = 1'b0;
        send_str("ff\r");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(word_valid), 32'd1);
            check("bp_word", word_out, 32'h000000FF);
            check("bp_digits", 32'(word_digits), 32'd2);
            check("bp_char_ready", 32'(char_ready), 32'd0);
        end
        check("bp_no_handshake", 32'(words), 32'd4);
        word_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_valid_low", 32'(word_valid), 32'd0);
        check("bp_ready_high", 32'(char_ready), 32'd1);
        check("bp_word_taken", last_word, 32'h000000FF);

        send_str("\r\n\r\n");
        idle(3);
        check("empty_words", 32'(words), 32'd5);
        check("empty_errs", 32'(errs), 32'd2);

        send_str("AB");
        idle(1);
        rst_n = 1'b0;
        #1 check_reset_outputs("midline_reset");
        @(negedge clk) rst_n = 1'b1;
        send_str("C\r");
        idle(3);
        check("after_rst_word", last_word, 32'h0000000C);
        check("after_rst_digits", 32'(last_digits), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/hex_word_assembler.md
# hex_word_assembler

Line-oriented ASCII hex accumulator sitting directly downstream of the character source (UART receive path) and wrapping the registered `hexDecoderUnit`. It accepts one character per handshake, routes hex digits through the decoder, and shifts the resulting nibbles into a right-aligned word. A CR or LF terminates the line and presents the word on a valid/ready output. Malformed or overlong lines are reported by an error pulse and discarded up to the next terminator.

## Interface
- `DIGITS`, default 8: maximum hex digits per word; word width is `4*DIGITS`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `char_in`  in  8  ASCII character; valid when `char_valid` is high.
- `char_valid`  in  1  upstream has a character.
- `char_ready`  out  1  block accepts `char_in` this cycle.
- `word_out`  out  `4*DIGITS`  assembled word, zero-extended, stable while `word_valid` is high.
- `word_digits`  out  `$clog2(DIGITS+1)`  number of digits in `word_out`.
- `word_valid`  out  1  `word_out` is available.
- `word_ready`  in  1  downstream consumes the word.
- `error`  out  1  one-cycle pulse per rejected line.
- `err_cause`  out  2  0=none, 1=BADCHAR, 2=OVERFLOW; held until the next error or reset.

## Operation
- Accept: `char_valid && char_ready` at a rising edge.
- States: ACCEPT, DECODE, OUTPUT, FLUSH. Reset enters ACCEPT.
- `char_ready` = 1 in ACCEPT and FLUSH, 0 in DECODE and OUTPUT.
- ACCEPT, terminator (0x0D or 0x0A):
  - count > 0: go to OUTPUT.
  - count = 0: ignore and stay in ACCEPT (empty line, CRLF pairs).
- ACCEPT, other character with count = DIGITS: `error`=1, `err_cause`=OVERFLOW, go to FLUSH. The character is not decoded.
- ACCEPT, other character with count < DIGITS: the decoder samples `char_in` on the same edge; go to DECODE.
- DECODE, decoder error: `error`=1, `err_cause`=BADCHAR, clear acc/count, go to FLUSH.
- DECODE, decoder OK: `acc <= {acc[4*DIGITS-5:0], nibble}`, count+1, go to ACCEPT.
- OUTPUT: `word_valid`=1; `word_out`=acc; `word_digits`=count.
  - On `word_ready`: clear acc/count, go to ACCEPT.
- FLUSH: accept and discard characters.
  - On terminator: clear acc/count, go to ACCEPT. No word is produced.
- Case: upper and lower case A–F are equivalent.
- Reset mid-line or mid-OUTPUT: the partial or pending word is discarded.

## Timing
- Reset values:
  - `char_ready`=1
  - `word_out`=0
  - `word_digits`=0
  - `word_valid`=0
  - `error`=0
  - `err_cause`=0
- Hex digit throughput is one per 2 cycles: accept edge N, decoder result edge N+1, ready again after N+1.
- Terminator accepted at edge T: `word_valid` high after T.
- Output handshake completes at the first edge with `word_ready`=1. `word_valid` is low after it, and `char_ready` is high in that same cycle.
- BADCHAR pulse is high for the cycle after edge N+1 (N = accept edge). OVERFLOW pulse is high for the cycle after the accept edge.
- `word_out`/`word_digits` hold their last value outside OUTPUT. They are only meaningful with `word_valid`.

## Structure
- Package `hex_pkg` contains:
  - state enum `hex_asm_state_t`
  - `err_cause_t` enum
  - `CHAR_CR`=8'h0D and `CHAR_LF`=8'h0A
- Sub-module: one instance of the existing `hexDecoderUnit`, with `char_in` driven directly into `nibbleChar`. It has no reset; the FSM ignores its outputs outside DECODE.

## Test plan
- Case digits (DIGITS=8, `word_ready`=1): "1A3F\r" → word 0x00001A3F, digits 4, one-cycle `word_valid`. Then "deadBEEF\n" → 0xDEADBEEF, digits 8.
- Bad character: "12G4\n" → error pulse with cause 1 two cycles after 'G' is accepted, no word. Then "7\r" → 0x00000007.
- Overflow: "123456789\r" → error with cause 2 after '9' is accepted, no word. Then "\n5\n" → 0x5.
- Backpressure: "ff\r" with `word_ready` low for 5 cycles → `word_valid` and 0x000000FF held stable, `char_ready`=0. Release → handshake, `char_ready`=1 the same cycle.
- Empty lines: "\r\n\r\n" → no word, no error.
- Reset mid-line: `rst_n` low after "AB" → all outputs at reset values. Then "C\r" → 0x0000000C, digits 1.
